// File: rtl/issue_sched.sv
// issue_sched: dual-issue scheduler / hazard controller for the 2-slot in-order pipeline.
// Produces the global write enables, per-slot issue stalls, mispredict flush and refill
// bubbles, using a load-use scoreboard and a RUN/REFILL/DRAIN recovery FSM.
//
// Ports
//   clock_i, reset_n_i          clock, async active-low reset
//   *_stall_i                   per-stage stall requests (any one freezes the backend)
//   iss0_* / iss1_*             issue-slot descriptors (slot0 is the older instruction)
//   exec_wrong_branch_i         exec-stage mispredict
//   backend_we_o                all post-issue buffers advance
//   frontend_we_o               PC/F2/decode/issue buffers advance
//   issue0_stall_o              hold the pair, bubble both exec slots
//   issue1_stall_o              slot0 issues, slot1 held and its exec slot bubbled
//   flush_o                     squash F2..issue, bubble exec
//   bubble_o                    zero the issue->exec transfer while refilling
//   sb_busy_o                   any scoreboard counter nonzero
//   state_o                     00 RUN, 01 REFILL, 10 DRAIN
//
// state  | meaning
// RUN    | normal dual issue with hazard checks
// REFILL | post-mispredict bubbles while the frontend refetches
// DRAIN  | fence waiting for outstanding loads; pair held
module issue_sched #(
  parameter int LOAD_LAT         = 2,
  parameter int REDIRECT_BUBBLES = 2
) (
  input  logic       clock_i,
  input  logic       reset_n_i,
  input  logic       f1_stall_i,
  input  logic       f2_stall_i,
  input  logic       dec_stall_i,
  input  logic       exec_stall_i,
  input  logic       mem_stall_i,
  input  logic       wb_stall_i,
  input  logic       iss0_valid_i,
  input  logic [4:0] iss0_rs1_i,
  input  logic [4:0] iss0_rs2_i,
  input  logic [4:0] iss0_rd_i,
  input  logic       iss0_we_i,
  input  logic       iss0_load_i,
  input  logic       iss0_mem_i,
  input  logic       iss0_fence_i,
  input  logic       iss1_valid_i,
  input  logic [4:0] iss1_rs1_i,
  input  logic [4:0] iss1_rs2_i,
  input  logic [4:0] iss1_rd_i,
  input  logic       iss1_we_i,
  input  logic       iss1_load_i,
  input  logic       iss1_mem_i,
  input  logic       exec_wrong_branch_i,
  output logic       backend_we_o,
  output logic       frontend_we_o,
  output logic       issue0_stall_o,
  output logic       issue1_stall_o,
  output logic       flush_o,
  output logic       bubble_o,
  output logic       sb_busy_o,
  output logic [1:0] state_o
);

  localparam int              SBW        = $clog2(LOAD_LAT + 1);
  localparam logic [SBW-1:0]  SB_SET     = SBW'(LOAD_LAT);
  localparam logic [SBW-1:0]  SB_ONE     = SBW'(1);
  localparam bit              HAS_REFILL = (REDIRECT_BUBBLES > 0);
  localparam logic [2:0]      RB_RELOAD  = HAS_REFILL ? 3'(REDIRECT_BUBBLES - 1) : 3'd0;

  typedef enum logic [1:0] {
    S_RUN    = 2'b00,
    S_REFILL = 2'b01,
    S_DRAIN  = 2'b10
  } state_e;

  state_e         state_q;
  logic [2:0]     cnt_q;
  logic [SBW-1:0] sb_q [32];
  logic [SBW-1:0] sb_d [32];

  logic hz0, hz1, sb_busy, issue_ok, issue0, issue1, set0, set1, fence_issue;
  logic sb_hit0, sb_hit1, raw01;

  // Slot1 is the younger instruction of the pair, so its write flag never feeds a hazard.
  logic unused_iss1_we;
  assign unused_iss1_we = iss1_we_i;

  assign backend_we_o = !(f1_stall_i | f2_stall_i | dec_stall_i |
                          exec_stall_i | mem_stall_i | wb_stall_i);
  assign flush_o      = exec_wrong_branch_i & backend_we_o;

  always_comb begin
    sb_busy = 1'b0;
    for (int r = 0; r < 32; r++) sb_busy = sb_busy | (sb_q[r] != '0);
  end
  assign sb_busy_o = sb_busy;

  // x0 never hazards, whatever its counter holds.
  assign sb_hit0 = ((iss0_rs1_i != 5'd0) && (sb_q[iss0_rs1_i] != '0)) ||
                   ((iss0_rs2_i != 5'd0) && (sb_q[iss0_rs2_i] != '0));
  assign sb_hit1 = ((iss1_rs1_i != 5'd0) && (sb_q[iss1_rs1_i] != '0)) ||
                   ((iss1_rs2_i != 5'd0) && (sb_q[iss1_rs2_i] != '0));
  assign raw01   = iss0_we_i && (iss0_rd_i != 5'd0) &&
                   ((iss1_rs1_i == iss0_rd_i) || (iss1_rs2_i == iss0_rd_i));

  assign hz0 = iss0_valid_i & sb_hit0;
  assign hz1 = iss1_valid_i & (sb_hit1 | raw01 | (iss0_mem_i & iss1_mem_i) | iss0_fence_i);

  assign issue0_stall_o = backend_we_o & !exec_wrong_branch_i &
                          ((state_q == S_DRAIN) | ((state_q == S_RUN) & hz0));
  assign issue1_stall_o = backend_we_o & !exec_wrong_branch_i &
                          (state_q == S_RUN) & !hz0 & hz1;
  assign frontend_we_o  = backend_we_o & !issue0_stall_o & !issue1_stall_o;
  assign bubble_o       = (state_q == S_REFILL);
  assign state_o        = state_q;

  assign issue_ok    = backend_we_o & (state_q == S_RUN) & !flush_o;
  assign issue0      = issue_ok & !issue0_stall_o;
  assign issue1      = issue0 & !issue1_stall_o;
  assign set0        = issue0 & iss0_valid_i & iss0_load_i & (iss0_rd_i != 5'd0);
  assign set1        = issue1 & iss1_valid_i & iss1_load_i & (iss1_rd_i != 5'd0);
  assign fence_issue = issue0 & iss0_valid_i & iss0_fence_i;

  // A fresh set wins over the decrement; slot1 is younger so it wins a same-rd race.
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      sb_d[r] = sb_q[r];
      if (r == 0)                              sb_d[r] = '0;
      else if (set1 && (iss1_rd_i == 5'(r)))   sb_d[r] = SB_SET;
      else if (set0 && (iss0_rd_i == 5'(r)))   sb_d[r] = SB_SET;
      else if (sb_q[r] != '0)                  sb_d[r] = sb_q[r] - SB_ONE;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_RUN;
      cnt_q   <= 3'd0;
      for (int r = 0; r < 32; r++) sb_q[r] <= '0;
    end else if (backend_we_o) begin
      for (int r = 0; r < 32; r++) sb_q[r] <= sb_d[r];
      case (state_q)
        S_RUN: begin
          if (flush_o) begin
            if (HAS_REFILL) begin
              state_q <= S_REFILL;
              cnt_q   <= RB_RELOAD;
            end
          end else if (fence_issue && sb_busy) begin
            state_q <= S_DRAIN;
          end
        end
        S_REFILL: begin
          if (flush_o)               cnt_q   <= RB_RELOAD;
          else if (cnt_q == 3'd0)    state_q <= S_RUN;
          else                       cnt_q   <= cnt_q - 3'd1;
        end
        S_DRAIN: begin
          if (flush_o) begin
            if (HAS_REFILL) begin
              state_q <= S_REFILL;
              cnt_q   <= RB_RELOAD;
            end else begin
              state_q <= S_RUN;
            end
          end else if (!sb_busy) begin
            state_q <= S_RUN;
          end
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_issue_sched.sv
module tb_issue_sched;

  logic       clock;
  logic       reset_n;
  logic       f1_stall, f2_stall, dec_stall, exec_stall, mem_stall, wb_stall;
  logic       i0_valid, i0_we, i0_load, i0_mem, i0_fence;
  logic [4:0] i0_rs1, i0_rs2, i0_rd;
  logic       i1_valid, i1_we, i1_load, i1_mem;
  logic [4:0] i1_rs1, i1_rs2, i1_rd;
  logic       wrong_branch;

  logic       backend_we, frontend_we, issue0_stall, issue1_stall, flush, bubble, sb_busy;
  logic [1:0] state;
  logic       b_backend_we, b_frontend_we, b_issue0_stall, b_issue1_stall, b_flush, b_bubble, b_sb_busy;
  logic [1:0] b_state;

  int checks   = 0;
  int failures = 0;

  issue_sched u_dut (
    .clock_i(clock), .reset_n_i(reset_n),
    .f1_stall_i(f1_stall), .f2_stall_i(f2_stall), .dec_stall_i(dec_stall),
    .exec_stall_i(exec_stall), .mem_stall_i(mem_stall), .wb_stall_i(wb_stall),
    .iss0_valid_i(i0_valid), .iss0_rs1_i(i0_rs1), .iss0_rs2_i(i0_rs2), .iss0_rd_i(i0_rd),
    .iss0_we_i(i0_we), .iss0_load_i(i0_load), .iss0_mem_i(i0_mem), .iss0_fence_i(i0_fence),
    .iss1_valid_i(i1_valid), .iss1_rs1_i(i1_rs1), .iss1_rs2_i(i1_rs2), .iss1_rd_i(i1_rd),
    .iss1_we_i(i1_we), .iss1_load_i(i1_load), .iss1_mem_i(i1_mem),
    .exec_wrong_branch_i(wrong_branch),
    .backend_we_o(backend_we), .frontend_we_o(frontend_we),
    .issue0_stall_o(issue0_stall), .issue1_stall_o(issue1_stall),
    .flush_o(flush), .bubble_o(bubble), .sb_busy_o(sb_busy), .state_o(state)
  );

  issue_sched #(.REDIRECT_BUBBLES(0)) u_dut_rb0 (
    .clock_i(clock), .reset_n_i(reset_n),
    .f1_stall_i(f1_stall), .f2_stall_i(f2_stall), .dec_stall_i(dec_stall),
    .exec_stall_i(exec_stall), .mem_stall_i(mem_stall), .wb_stall_i(wb_stall),
    .iss0_valid_i(i0_valid), .iss0_rs1_i(i0_rs1), .iss0_rs2_i(i0_rs2), .iss0_rd_i(i0_rd),
    .iss0_we_i(i0_we), .iss0_load_i(i0_load), .iss0_mem_i(i0_mem), .iss0_fence_i(i0_fence),
    .iss1_valid_i(i1_valid), .iss1_rs1_i(i1_rs1), .iss1_rs2_i(i1_rs2), .iss1_rd_i(i1_rd),
    .iss1_we_i(i1_we), .iss1_load_i(i1_load), .iss1_mem_i(i1_mem),
    .exec_wrong_branch_i(wrong_branch),
    .backend_we_o(b_backend_we), .frontend_we_o(b_frontend_we),
    .issue0_stall_o(b_issue0_stall), .issue1_stall_o(b_issue1_stall),
    .flush_o(b_flush), .bubble_o(b_bubble), .sb_busy_o(b_sb_busy), .state_o(b_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    {f1_stall, f2_stall, dec_stall, exec_stall, mem_stall, wb_stall} = 6'b0;
    {i0_valid, i0_we, i0_load, i0_mem, i0_fence} = 5'b0;
    i0_rs1 = 5'd0; i0_rs2 = 5'd0; i0_rd = 5'd0;
    {i1_valid, i1_we, i1_load, i1_mem} = 4'b0;
    i1_rs1 = 5'd0; i1_rs2 = 5'd0; i1_rd = 5'd0;
    wrong_branch = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // slot0 load into rd
  task automatic s0_load(input logic [4:0] rd);
    i0_valid = 1; i0_load = 1; i0_mem = 1; i0_we = 1; i0_rd = rd; i0_rs1 = 5'd1; i0_rs2 = 5'd0;
  endtask

  // slot0 ALU op rd <- rs1
  task automatic s0_alu(input logic [4:0] rd, input logic [4:0] rs1);
    i0_valid = 1; i0_load = 0; i0_mem = 0; i0_we = 1; i0_rd = rd; i0_rs1 = rs1; i0_rs2 = 5'd0;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    #3;
    chk("rst_backend_we", backend_we, 1);
    chk("rst_frontend_we", frontend_we, 1);
    chk("rst_stalls", {issue0_stall, issue1_stall}, 0);
    chk("rst_flush_bubble", {flush, bubble}, 0);
    chk("rst_state", state, 0);
    chk("rst_sb_busy", sb_busy, 0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    // each stage stall alone freezes both enables
    for (int i = 0; i < 6; i++) begin
      idle();
      {f1_stall, f2_stall, dec_stall, exec_stall, mem_stall, wb_stall} = 6'(1 << i);
      #1;
      chk("stall_backend_we", backend_we, 0);
      chk("stall_frontend_we", frontend_we, 0);
    end
    idle();
    tick();

    // load-use on slot0
    idle(); s0_load(5'd5); #1;
    chk("lu_n_stall0", issue0_stall, 0);
    chk("lu_n_busy", sb_busy, 0);
    tick();
    idle(); s0_alu(5'd6, 5'd5); #1;
    chk("lu_n1_stall0", issue0_stall, 1);
    chk("lu_n1_busy", sb_busy, 1);
    chk("lu_n1_frontend", frontend_we, 0);
    tick(); #1;
    chk("lu_n2_stall0", issue0_stall, 1);
    chk("lu_n2_busy", sb_busy, 1);
    tick(); #1;
    chk("lu_n3_stall0", issue0_stall, 0);
    chk("lu_n3_busy", sb_busy, 0);
    chk("lu_n3_frontend", frontend_we, 1);
    tick();

    // intra-pair RAW
    idle(); s0_alu(5'd3, 5'd0);
    i1_valid = 1; i1_we = 1; i1_rd = 5'd4; i1_rs1 = 5'd3; #1;
    chk("raw_stall1", issue1_stall, 1);
    chk("raw_stall0", issue0_stall, 0);
    chk("raw_frontend", frontend_we, 0);
    tick();
    {i0_valid, i0_we} = 2'b0; i0_rd = 5'd0; #1;
    chk("raw_alone_stall1", issue1_stall, 0);
    chk("raw_alone_frontend", frontend_we, 1);
    tick();

    // structural mem/mem pair
    idle(); s0_load(5'd7);
    i1_valid = 1; i1_mem = 1; i1_rs1 = 5'd2; i1_rs2 = 5'd8; #1;
    chk("mem_stall1", issue1_stall, 1);
    chk("mem_stall0", issue0_stall, 0);
    chk("mem_frontend", frontend_we, 0);
    tick();
    {i0_valid, i0_we, i0_load, i0_mem} = 4'b0; #1;
    chk("mem_alone_stall1", issue1_stall, 0);
    chk("mem_alone_frontend", frontend_we, 1);
    tick();
    idle(); #1;
    chk("mem_sb_busy", sb_busy, 1);
    tick(); #1;
    chk("mem_sb_empty", sb_busy, 0);

    // slot1 scoreboard hit
    idle(); s0_load(5'd5); tick();
    s0_alu(5'd11, 5'd0);
    i1_valid = 1; i1_we = 1; i1_rd = 5'd12; i1_rs1 = 5'd5; #1;
    chk("sb1_stall1", issue1_stall, 1);
    chk("sb1_stall0", issue0_stall, 0);
    tick();
    {i0_valid, i0_we} = 2'b0; i0_rd = 5'd0; #1;
    chk("sb1_still_stall1", issue1_stall, 1);
    tick(); #1;
    chk("sb1_clear_stall1", issue1_stall, 0);
    tick();

    // x0 never hazards
    idle(); s0_load(5'd0); tick();
    s0_alu(5'd0, 5'd0);
    i1_valid = 1; i1_we = 1; i1_rd = 5'd9; #1;
    chk("x0_stall0", issue0_stall, 0);
    chk("x0_stall1", issue1_stall, 0);
    chk("x0_busy", sb_busy, 0);
    tick();

    // mispredict -> REFILL x2; bubbles=0 instance stays in RUN
    idle(); wrong_branch = 1; #1;
    chk("br_flush", flush, 1);
    chk("br_flush_rb0", b_flush, 1);
    chk("br_stall0", issue0_stall, 0);
    tick();
    wrong_branch = 0; #1;
    chk("br_c1_state", state, 1);
    chk("br_c1_bubble", bubble, 1);
    chk("br_c1_frontend", frontend_we, 1);
    chk("br_c1_state_rb0", b_state, 0);
    chk("br_c1_bubble_rb0", b_bubble, 0);
    tick(); #1;
    chk("br_c2_state", state, 1);
    chk("br_c2_bubble", bubble, 1);
    tick(); #1;
    chk("br_c3_state", state, 0);
    chk("br_c3_bubble", bubble, 0);

    // backend stall freezes scoreboard and FSM
    idle(); s0_load(5'd5); tick();
    s0_alu(5'd6, 5'd5); mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) wrong_branch = 1;
      #1;
      chk("frz_backend", backend_we, 0);
      chk("frz_stall0", issue0_stall, 0);
      chk("frz_flush", flush, 0);
      chk("frz_busy", sb_busy, 1);
      tick();
    end
    mem_stall = 0; wrong_branch = 0; #1;
    chk("frz_r1_state", state, 0);
    chk("frz_r1_stall0", issue0_stall, 1);
    tick(); #1;
    chk("frz_r2_stall0", issue0_stall, 1);
    tick(); #1;
    chk("frz_r3_stall0", issue0_stall, 0);
    chk("frz_r3_busy", sb_busy, 0);
    tick();

    // fence drains outstanding loads
    idle(); s0_load(5'd9); tick();
    idle(); i0_valid = 1; i0_fence = 1; #1;
    chk("fn_enter_state", state, 0);
    chk("fn_enter_stall0", issue0_stall, 0);
    tick(); #1;
    chk("fn_d1_state", state, 2);
    chk("fn_d1_stall0", issue0_stall, 1);
    chk("fn_d1_frontend", frontend_we, 0);
    chk("fn_d1_busy", sb_busy, 1);
    tick(); #1;
    chk("fn_d2_state", state, 2);
    chk("fn_d2_busy", sb_busy, 0);
    tick(); #1;
    chk("fn_run_state", state, 0);
    chk("fn_run_stall0", issue0_stall, 0);
    chk("fn_run_frontend", frontend_we, 1);
    tick();

    // mispredict while draining
    idle(); s0_load(5'd9); tick();
    idle(); i0_valid = 1; i0_fence = 1; tick(); #1;
    chk("fd_state", state, 2);
    wrong_branch = 1; #1;
    chk("fd_flush", flush, 1);
    chk("fd_stall0", issue0_stall, 0);
    tick();
    idle(); #1;
    chk("fd_refill_state", state, 1);
    chk("fd_refill_bubble", bubble, 1);
    tick(); tick(); #1;
    chk("fd_back_run", state, 0);

    // async reset mid-REFILL with scoreboard busy
    idle(); s0_load(5'd5); tick();
    idle(); wrong_branch = 1; tick();
    wrong_branch = 0; #1;
    chk("ar_pre_state", state, 1);
    chk("ar_pre_busy", sb_busy, 1);
    mem_stall = 1;
    reset_n = 0; #1;
    chk("ar_state", state, 0);
    chk("ar_busy", sb_busy, 0);
    chk("ar_bubble", bubble, 0);
    #1 reset_n = 1;
    idle(); tick(); #1;
    chk("ar_post_backend", backend_we, 1);
    chk("ar_post_frontend", frontend_we, 1);
    chk("ar_post_state", state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
